// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch controller.
// Imported by fetch_ctrl and fetch_buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    HOLD,
    SQUASH
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  localparam logic [15:0] DEF_PC_INCR = 16'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction queue.
// Slot 0 is always the head; flush wins over push/pop.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slot0_q, slot1_q;
  logic [1:0]   count_q;
  logic         do_pop, do_push;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else if (do_push && do_pop) begin
      if (count_q == 2'd1) begin
        slot0_q <= din;
      end else begin
        slot0_q <= slot1_q;
        slot1_q <= din;
      end
    end else if (do_pop) begin
      slot0_q <= slot1_q;
      count_q <= count_q - 2'd1;
    end else if (do_push) begin
      if (count_q == 2'd0) slot0_q <= din;
      else                 slot1_q <= din;
      count_q <= count_q + 2'd1;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one read at a time,
// queues results for decode and handles branch redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_INCR   = DEF_PC_INCR,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [15:0] mem_data,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  fetch_state_t state_q, state_d;
  logic [15:0]  fetch_pc_q, fetch_pc_d;
  logic [15:0]  redirect_pc_q, redirect_pc_d;
  logic         push, pop, flush;
  logic [1:0]   count, post_cnt;
  fetch_entry_t head, push_entry;

  assign push_entry = '{pc: fetch_pc_q, instr: mem_data};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    push          = 1'b0;
    flush         = branch_taken;
    pop           = instr_valid && !stall;
    post_cnt      = count + 2'd1 - {1'b0, pop};
    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        if (branch_taken) fetch_pc_d = branch_target;
      end
      REQ: begin
        if (branch_taken) begin
          if (mem_rdy) begin
            fetch_pc_d = branch_target;
          end else begin
            // read in flight: hold its address until it drains
            redirect_pc_d = branch_target;
            state_d       = SQUASH;
          end
        end else if (mem_rdy) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INCR;
          state_d    = (post_cnt == DEPTH) ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          fetch_pc_d = branch_target;
          state_d    = REQ;
        end else if (count < DEPTH) begin
          state_d = REQ;
        end
      end
      SQUASH: begin
        if (mem_rdy) begin
          fetch_pc_d = branch_taken ? branch_target : redirect_pc_q;
          state_d    = REQ;
        end else if (branch_taken) begin
          redirect_pc_d = branch_target;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign mem_rd_en   = (state_q == REQ) || (state_q == SQUASH);
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = (count != 2'd0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a tiny memory model
// (data = addr ^ A5A5, optional zero-wait ready).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        mem_rdy;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  logic zw;
  logic rdy_drv;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign mem_rdy  = zw ? mem_rd_en : rdy_drv;
  assign mem_data = mem_addr ^ 16'hA5A5;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdy       (mem_rdy),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0; zw = 1'b1; rdy_drv = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    chk("rst_rd_en", 16'(mem_rd_en), 16'h0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc", instr_pc, 16'h0000);

    // zero-wait sequential fetch
    tick();
    chk("seq_rd_en1", 16'(mem_rd_en), 16'h1);
    chk("seq_addr0", mem_addr, 16'h0000);
    chk("seq_valid1", 16'(instr_valid), 16'h0);
    tick();
    chk("seq_valid2", 16'(instr_valid), 16'h1);
    chk("seq_pc0", instr_pc, 16'h0000);
    chk("seq_instr0", instr, 16'hA5A5);
    chk("seq_addr4", mem_addr, 16'h0004);
    tick();
    chk("seq_pc4", instr_pc, 16'h0004);
    chk("seq_instr4", instr, 16'hA5A1);
    chk("seq_addr8", mem_addr, 16'h0008);

    // stall fills the buffer then HOLD
    stall = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    chk("hold_rd_en", 16'(mem_rd_en), 16'h0);
    chk("hold_pc", instr_pc, 16'h0000);
    chk("hold_valid", 16'(instr_valid), 16'h1);
    tick();
    chk("hold_rd_en2", 16'(mem_rd_en), 16'h0);
    chk("hold_keep", instr_pc, 16'h0000);
    stall = 1'b0;
    tick();
    chk("deq_pc4", instr_pc, 16'h0004);
    chk("deq_rd_en", 16'(mem_rd_en), 16'h0);
    tick();
    chk("resume_rd_en", 16'(mem_rd_en), 16'h1);
    chk("resume_addr", mem_addr, 16'h0008);
    chk("resume_empty", 16'(instr_valid), 16'h0);
    tick();
    chk("resume_pc8", instr_pc, 16'h0008);

    // 3-cycle memory, redirect on second wait cycle
    zw = 1'b0; rdy_drv = 1'b0;
    do_reset();
    tick();
    chk("slow_addr0", mem_addr, 16'h0000);
    tick();
    branch_taken = 1'b1; branch_target = 16'h0100;
    tick();
    branch_taken = 1'b0;
    chk("sq_addr_hold", mem_addr, 16'h0000);
    chk("sq_rd_en", 16'(mem_rd_en), 16'h1);
    rdy_drv = 1'b1;
    tick();
    rdy_drv = 1'b0;
    chk("sq_new_addr", mem_addr, 16'h0100);
    chk("sq_dropped", 16'(instr_valid), 16'h0);
    tick();
    chk("sq_w1_empty", 16'(instr_valid), 16'h0);
    tick();
    chk("sq_w2_empty", 16'(instr_valid), 16'h0);
    rdy_drv = 1'b1;
    tick();
    rdy_drv = 1'b0;
    chk("tgt_valid", 16'(instr_valid), 16'h1);
    chk("tgt_pc", instr_pc, 16'h0100);
    chk("tgt_instr", instr, 16'hA4A5);
    chk("tgt_next_addr", mem_addr, 16'h0104);

    // redirect coinciding with mem_rdy, one entry buffered
    stall = 1'b1;
    rdy_drv = 1'b1; branch_taken = 1'b1; branch_target = 16'h0200;
    tick();
    rdy_drv = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    chk("rdyb_empty", 16'(instr_valid), 16'h0);
    chk("rdyb_addr", mem_addr, 16'h0200);
    chk("rdyb_rd_en", 16'(mem_rd_en), 16'h1);

    // two redirects while squashing
    branch_taken = 1'b1; branch_target = 16'h0300;
    tick();
    branch_target = 16'h0400;
    chk("sq2_hold1", mem_addr, 16'h0200);
    tick();
    branch_taken = 1'b0;
    chk("sq2_hold2", mem_addr, 16'h0200);
    rdy_drv = 1'b1;
    tick();
    chk("sq2_addr", mem_addr, 16'h0400);
    chk("sq2_empty", 16'(instr_valid), 16'h0);
    tick();
    rdy_drv = 1'b0;
    chk("sq2_pc", instr_pc, 16'h0400);
    chk("sq2_instr", instr, 16'hA1A5);

    // redirect to FFFC then wrap
    zw = 1'b1;
    branch_taken = 1'b1; branch_target = 16'hFFFC;
    tick();
    branch_taken = 1'b0;
    chk("wrap_addr_fffc", mem_addr, 16'hFFFC);
    chk("wrap_flushed", 16'(instr_valid), 16'h0);
    tick();
    chk("wrap_addr_0", mem_addr, 16'h0000);
    chk("wrap_pc", instr_pc, 16'hFFFC);
    chk("wrap_instr", instr, 16'h5A59);

    // asynchronous reset in the middle of a read
    zw = 1'b0; rdy_drv = 1'b0;
    tick();
    chk("mid_rd_en", 16'(mem_rd_en), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en", 16'(mem_rd_en), 16'h0);
    chk("arst_addr", mem_addr, 16'h0000);
    chk("arst_valid", 16'(instr_valid), 16'h0);
    chk("arst_instr", instr, 16'h0000);
    chk("arst_pc", instr_pc, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rd_en", 16'(mem_rd_en), 16'h1);
    chk("post_rst_addr", mem_addr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer sitting between the pipeline front end and the instruction memory. It owns the fetch PC, issues one read at a time under a ready handshake, queues returned instructions with their PCs in a 2-entry buffer for decode, and handles branch redirects, including one that arrives while a read is still outstanding. It replaces the free-running PC update with a controller that tolerates variable memory latency and decode stalls.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset
- PC_INCR, 4, sequential PC increment
- BUF_DEPTH, 2, instruction buffer entries (fixed at 2 for this revision)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept this cycle
- branch_taken  in  1  redirect request, single-cycle pulse
- branch_target  in  16  redirect address, valid with branch_taken
- mem_rd_en  out  1  read request to instruction memory
- mem_addr  out  16  read address, stable while mem_rd_en high and mem_rdy low
- mem_rdy  in  1  read complete; mem_data valid this cycle
- mem_data  in  16  returned instruction
- instr_valid  out  1  buffer head valid
- instr  out  16  buffer head instruction
- instr_pc  out  16  PC of buffer head

## Operation
- Reset values: state BOOT, mem_rd_en 0, mem_addr RESET_PC, fetch_pc RESET_PC, buffer empty, instr_valid 0, instr 0, instr_pc 0.
- Dequeue occurs when instr_valid && !stall. Outputs always reflect the head entry.
- States:
  - BOOT: lasts one cycle, then REQ.
  - REQ: mem_rd_en=1, mem_addr=fetch_pc. On mem_rdy, enqueue {fetch_pc, mem_data} and set fetch_pc += PC_INCR (mod 2^16, wraps FFFC→0000). Next state is HOLD if post-update count == BUF_DEPTH, otherwise REQ.
  - HOLD: mem_rd_en=0. Moves to REQ when count < BUF_DEPTH.
  - SQUASH: mem_rd_en=1, mem_addr unchanged. Waits for mem_rdy, discards mem_data, sets fetch_pc=redirect_pc, then moves to REQ.
- Redirect (branch_taken) always flushes the buffer. Flush takes priority over a dequeue or enqueue in the same cycle.
  - BOOT/HOLD: fetch_pc ← target; next state REQ (BOOT still spends its one cycle).
  - REQ with mem_rdy: response discarded; fetch_pc ← target; next state REQ.
  - REQ without mem_rdy: redirect_pc ← target; next state SQUASH. mem_addr is held, because a read in flight cannot be withdrawn.
  - SQUASH: redirect_pc ← latest target; state remains SQUASH.
- Simultaneous enqueue and dequeue: count is unchanged and order is preserved.
- Asserting rst_n mid-read drops mem_rd_en immediately. The memory must tolerate an abandoned read.
- Count never exceeds BUF_DEPTH. Enqueue is only possible from REQ, which is entered only with space available.

## Timing
- Reset released before edge 0: BOOT in cycle 0, first mem_rd_en in cycle 1.
- Zero-wait memory (mem_rdy in the same cycle as mem_rd_en): instr_valid rises one cycle after the response. Sustained throughput is 1 instruction/cycle with no stall.
- N-cycle memory: one instruction per N cycles. Only one request is outstanding.
- Redirect to first target instruction, zero-wait memory: target is on mem_addr the cycle after branch_taken and valid at the head one cycle later.
- All outputs are registered or decoded from state/registers only. There is no combinational path from stall or branch_taken to mem_rd_en or mem_addr.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum {BOOT, REQ, HOLD, SQUASH}
  - fetch_entry_t struct {pc[15:0], instr[15:0]}
  - default PC_INCR constant
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, and a head output. It uses the same clk/rst_n.
- fetch_ctrl holds the FSM, fetch_pc, and redirect_pc.

## Test plan
- Reset, zero-wait memory, no stall → mem_addr sequence 0000, 0004, 0008; instr_valid from cycle 2; instr_pc matches each instruction.
- Hold stall high, zero-wait memory → two entries buffered, then HOLD with mem_rd_en=0. Release stall → in-order dequeue, then fetch resumes at 0008.
- 3-cycle memory, branch_taken to 0100 in the second wait cycle → mem_addr stays at the old address until mem_rdy, that data is never visible, and the next request is 0100.
- branch_taken to 0200 on the same cycle as mem_rdy, with the buffer holding one entry → buffer empty next cycle, mem_addr=0200, returned data dropped.
- Two redirects during SQUASH (0300, then 0400) → fetch resumes at 0400 only.
- fetch_pc=FFFC, sequential fetch → next mem_addr is 0000. Separately, pulse rst_n low mid-read → mem_rd_en=0 immediately, all outputs return to reset values, and the first read after release is at RESET_PC.
